// File: rtl/err_mon_pkg.sv
// Shared constants for the multi-channel timing-error monitor: default
// parameter values and the recovery FSM state encoding.
package err_mon_pkg;

  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_NUM_CH      = 4;
  localparam int DEF_CNT_WIDTH   = 8;
  localparam int DEF_WINDOW_LOG2 = 8;
  localparam int DEF_HOLDOFF     = 2;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_HOLDOFF = 2'd2;

endpackage

// File: rtl/err_mon_channel.sv
// One monitored channel: remembers the last valid main sample, flags a raw
// error when the main value transitioned and disagrees with the shadow
// sample, and keeps a saturating total of raw errors.
module err_mon_channel
  import err_mon_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid,
  input  logic                  mask,
  input  logic                  clr,
  input  logic [DATA_WIDTH-1:0] data_main,
  input  logic [DATA_WIDTH-1:0] data_shadow,
  output logic                  raw_err,
  output logic [CNT_WIDTH-1:0]  err_cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [DATA_WIDTH-1:0] prev_q, prev_d;
  logic                  prev_vld_q, prev_vld_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  // Error detection, history update and saturating count; clear beats increment.
  always_comb begin
    raw_err    = valid & prev_vld_q & (data_main != prev_q) &
                 (data_main != data_shadow) & ~mask;
    prev_d     = valid ? data_main : prev_q;
    prev_vld_d = prev_vld_q | valid;
    cnt_d      = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (raw_err && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Channel state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
      cnt_q      <= cnt_d;
    end
  end

  assign err_cnt = cnt_q;

endmodule

// File: rtl/multi_channel_error_monitor.sv
// Multi-channel timing-error monitor: per-channel detectors, a recovery
// request/acknowledge FSM with post-recovery holdoff, and a windowed
// error-rate flag for voltage/frequency control.
module multi_channel_error_monitor
  import err_mon_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
  parameter int WINDOW_LOG2 = DEF_WINDOW_LOG2,
  parameter int HOLDOFF     = DEF_HOLDOFF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic [NUM_CH-1:0]             ch_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0]  data_main,
  input  logic [NUM_CH*DATA_WIDTH-1:0]  data_shadow,
  input  logic                          recover_ack,
  input  logic                          clr_cnt,
  input  logic [CNT_WIDTH-1:0]          thresh,
  output logic [NUM_CH-1:0]             error_vec,
  output logic                          error_any,
  output logic                          recover_req,
  output logic [NUM_CH-1:0]             recover_ch,
  output logic [NUM_CH*CNT_WIDTH-1:0]   err_cnt,
  output logic                          degrade
);

  localparam int HO_W  = $clog2(HOLDOFF + 1);
  localparam int PC_W  = $clog2(NUM_CH + 1);
  localparam int SUM_W = CNT_WIDTH + PC_W;
  localparam logic [SUM_W-1:0] WIN_MAX = SUM_W'({CNT_WIDTH{1'b1}});

  logic [NUM_CH-1:0]      raw;
  logic                   det_mask;
  logic [1:0]             state_q, state_d;
  logic [NUM_CH-1:0]      recover_ch_q, recover_ch_d;
  logic [HO_W-1:0]        ho_cnt_q, ho_cnt_d;
  logic [NUM_CH-1:0]      error_vec_q, error_vec_d;
  logic                   error_any_q, error_any_d;
  logic [WINDOW_LOG2-1:0] wcyc_q, wcyc_d;
  logic [CNT_WIDTH-1:0]   win_cnt_q, win_cnt_d;
  logic                   degrade_q, degrade_d;
  logic [PC_W-1:0]        pop;
  logic [SUM_W-1:0]       win_sum;

  function automatic logic [PC_W-1:0] popcount(input logic [NUM_CH-1:0] v);
    logic [PC_W-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      n = n + PC_W'(v[i]);
    end
    return n;
  endfunction

  // Detection is blanked while disabled and for the whole holdoff period.
  assign det_mask = ~en | (state_q == ST_HOLDOFF);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    err_mon_channel #(
      .DATA_WIDTH (DATA_WIDTH),
      .CNT_WIDTH  (CNT_WIDTH)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .valid       (ch_valid[g]),
      .mask        (det_mask),
      .clr         (clr_cnt),
      .data_main   (data_main[g*DATA_WIDTH +: DATA_WIDTH]),
      .data_shadow (data_shadow[g*DATA_WIDTH +: DATA_WIDTH]),
      .raw_err     (raw[g]),
      .err_cnt     (err_cnt[g*CNT_WIDTH +: CNT_WIDTH])
    );
  end

  // Recovery FSM; an ack in REQ wins over a coincident raw error.
  always_comb begin
    state_d      = state_q;
    recover_ch_d = recover_ch_q;
    ho_cnt_d     = ho_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (|raw) begin
          state_d      = ST_REQ;
          recover_ch_d = raw;
        end
      end
      ST_REQ: begin
        if (recover_ack) begin
          state_d  = ST_HOLDOFF;
          ho_cnt_d = HO_W'(HOLDOFF);
        end else begin
          recover_ch_d = recover_ch_q | raw;
        end
      end
      ST_HOLDOFF: begin
        ho_cnt_d = ho_cnt_q - 1'b1;
        if (ho_cnt_q == HO_W'(1)) begin
          state_d      = ST_IDLE;
          recover_ch_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Error pulses and the windowed rate accumulator with wrap-time decision.
  always_comb begin
    error_vec_d = raw;
    error_any_d = |raw;
    pop         = popcount(raw);
    win_sum     = SUM_W'(win_cnt_q) + SUM_W'(pop);
    wcyc_d      = wcyc_q + 1'b1;
    win_cnt_d   = (win_sum > WIN_MAX) ? win_cnt_q | '1 : win_sum[CNT_WIDTH-1:0];
    degrade_d   = degrade_q;
    if (&wcyc_q) begin
      degrade_d = (thresh != '0) && (win_sum >= SUM_W'(thresh));
      win_cnt_d = '0;
    end
    if (clr_cnt) begin
      win_cnt_d = '0;
    end
  end

  // All monitor state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      recover_ch_q <= '0;
      ho_cnt_q     <= '0;
      error_vec_q  <= '0;
      error_any_q  <= 1'b0;
      wcyc_q       <= '0;
      win_cnt_q    <= '0;
      degrade_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      recover_ch_q <= recover_ch_d;
      ho_cnt_q     <= ho_cnt_d;
      error_vec_q  <= error_vec_d;
      error_any_q  <= error_any_d;
      wcyc_q       <= wcyc_d;
      win_cnt_q    <= win_cnt_d;
      degrade_q    <= degrade_d;
    end
  end

  assign error_vec   = error_vec_q;
  assign error_any   = error_any_q;
  assign recover_req = (state_q == ST_REQ);
  assign recover_ch  = recover_ch_q;
  assign degrade     = degrade_q;

endmodule

// File: tb/tb_multi_channel_error_monitor.sv
// Scoreboard bench for multi_channel_error_monitor. Two instances share the
// stimulus: dut_a (8-bit counters, 8-cycle window) and dut_s (2-bit
// counters, rate flag disabled) to exercise counter saturation.
module tb_multi_channel_error_monitor;

  logic         clk;
  logic         reset;
  logic         en;
  logic [3:0]   ch_valid;
  logic [31:0]  main_w [4];
  logic [31:0]  shad_w [4];
  logic [127:0] data_main;
  logic [127:0] data_shadow;
  logic         recover_ack;
  logic         clr_cnt;
  logic [7:0]   thresh;

  logic [3:0]   a_vec, s_vec;
  logic         a_any, s_any, a_req, s_req, a_deg, s_deg;
  logic [3:0]   a_ch, s_ch;
  logic [31:0]  cnt_a;
  logic [7:0]   cnt_s;

  typedef struct {
    string      tag;
    logic [3:0] vec;
    logic       req;
    logic [3:0] ch;
    logic       deg;
  } exp_t;

  exp_t sb[$];
  int   n_chk;
  int   n_pass;

  assign data_main   = {main_w[3], main_w[2], main_w[1], main_w[0]};
  assign data_shadow = {shad_w[3], shad_w[2], shad_w[1], shad_w[0]};

  multi_channel_error_monitor #(
    .DATA_WIDTH (32), .NUM_CH (4), .CNT_WIDTH (8), .WINDOW_LOG2 (3), .HOLDOFF (2)
  ) dut_a (
    .clk (clk), .reset (reset), .en (en), .ch_valid (ch_valid),
    .data_main (data_main), .data_shadow (data_shadow),
    .recover_ack (recover_ack), .clr_cnt (clr_cnt), .thresh (thresh),
    .error_vec (a_vec), .error_any (a_any), .recover_req (a_req),
    .recover_ch (a_ch), .err_cnt (cnt_a), .degrade (a_deg)
  );

  multi_channel_error_monitor #(
    .DATA_WIDTH (32), .NUM_CH (4), .CNT_WIDTH (2), .WINDOW_LOG2 (4), .HOLDOFF (2)
  ) dut_s (
    .clk (clk), .reset (reset), .en (en), .ch_valid (ch_valid),
    .data_main (data_main), .data_shadow (data_shadow),
    .recover_ack (recover_ack), .clr_cnt (clr_cnt), .thresh (2'b00),
    .error_vec (s_vec), .error_any (s_any), .recover_req (s_req),
    .recover_ch (s_ch), .err_cnt (cnt_s), .degrade (s_deg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_chk++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
  endtask

  task automatic setd(input int c, input logic [31:0] m, input logic [31:0] s);
    main_w[c] = m;
    shad_w[c] = s;
  endtask

  // One clock of stimulus; the expected registered response is queued when
  // driven and compared once the edge has produced it.
  task automatic step(input string tag, input logic [3:0] v, input logic ak,
                      input logic cl, input logic [3:0] evec, input logic ereq,
                      input logic [3:0] ech, input logic edeg);
    exp_t e;
    ch_valid    = v;
    recover_ack = ak;
    clr_cnt     = cl;
    sb.push_back('{tag: tag, vec: evec, req: ereq, ch: ech, deg: edeg});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({e.tag, ".vec"},   64'(a_vec), 64'(e.vec));
    check({e.tag, ".any"},   64'(a_any), 64'(|e.vec));
    check({e.tag, ".req"},   64'(a_req), 64'(e.req));
    check({e.tag, ".ch"},    64'(a_ch),  64'(e.ch));
    check({e.tag, ".deg"},   64'(a_deg), 64'(e.deg));
    check({e.tag, ".s_vec"}, 64'(s_vec), 64'(e.vec));
    check({e.tag, ".s_any"}, 64'(s_any), 64'(|e.vec));
    check({e.tag, ".s_req"}, 64'(s_req), 64'(e.req));
    check({e.tag, ".s_ch"},  64'(s_ch),  64'(e.ch));
    check({e.tag, ".s_deg"}, 64'(s_deg), 64'd0);
    ch_valid    = '0;
    recover_ack = 1'b0;
    clr_cnt     = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    reset = 1'b0; en = 1'b1; ch_valid = '0; recover_ack = 1'b0;
    clr_cnt = 1'b0; thresh = 8'd0;
    for (int i = 0; i < 4; i++) setd(i, 32'd0, 32'd0);

    step("rst0", 4'h0, 0, 0, 4'h0, 0, 4'h0, 0);
    step("rst1", 4'h0, 0, 0, 4'h0, 0, 4'h0, 0);
    check("rst.cnt_a", 64'(cnt_a), 64'd0);
    check("rst.cnt_s", 64'(cnt_s), 64'd0);
    reset = 1'b1;

    // First sample never errors; a real transition with mismatch does.
    setd(0, 32'h5, 32'h5); step("first", 4'b0001, 0, 0, 4'h0, 0, 4'h0, 0);
    setd(0, 32'h6, 32'h5); step("trans", 4'b0001, 0, 0, 4'b0001, 1, 4'b0001, 0);
    check("trans.cnt_a", 64'(cnt_a), 64'h0000_0001);
    check("trans.cnt_s", 64'(cnt_s), 64'h01);
    setd(0, 32'h6, 32'h7); step("notrans", 4'b0001, 0, 0, 4'h0, 1, 4'b0001, 0);
    check("notrans.cnt_a", 64'(cnt_a), 64'h0000_0001);

    // Ack and holdoff; prime channels 1 and 3 meanwhile.
    setd(1, 32'h10, 32'h10); setd(3, 32'h30, 32'h30);
    step("ack1", 4'b1010, 1, 0, 4'h0, 0, 4'b0001, 0);
    step("ho1a", 4'h0, 0, 0, 4'h0, 0, 4'b0001, 0);
    step("ho1b", 4'h0, 0, 0, 4'h0, 0, 4'h0, 0);

    // Errors on ch1 then ch3 accumulate into the sticky mask.
    setd(1, 32'h11, 32'h10); step("err_ch1", 4'b0010, 0, 0, 4'b0010, 1, 4'b0010, 0);
    setd(3, 32'h31, 32'h30); step("err_ch3", 4'b1000, 0, 0, 4'b1000, 1, 4'b1010, 0);
    step("ack2", 4'h0, 1, 0, 4'h0, 0, 4'b1010, 0);
    setd(1, 32'h12, 32'h11); step("ho2a", 4'b0010, 0, 0, 4'h0, 0, 4'b1010, 0);
    setd(1, 32'h13, 32'h12); step("ho2b", 4'b0010, 0, 0, 4'h0, 0, 4'h0, 0);
    check("holdoff.cnt_a", 64'(cnt_a), 64'h0100_0101);
    setd(1, 32'h14, 32'h13); step("live", 4'b0010, 0, 0, 4'b0010, 1, 4'b0010, 0);

    // Error coincident with ack: pulsed and counted, but no new request.
    setd(3, 32'h32, 32'h31); step("err_ack", 4'b1000, 1, 0, 4'b1000, 0, 4'b0010, 0);
    check("err_ack.cnt_a", 64'(cnt_a), 64'h0200_0201);
    step("ho3a",  4'h0, 0, 0, 4'h0, 0, 4'b0010, 0);
    step("ho3b",  4'h0, 0, 0, 4'h0, 0, 4'h0, 0);
    step("noreq", 4'h0, 0, 0, 4'h0, 0, 4'h0, 0);

    // Disabled detection suppresses errors.
    en = 1'b0;
    setd(1, 32'h15, 32'h14); step("en_off", 4'b0010, 0, 0, 4'h0, 0, 4'h0, 0);
    en = 1'b1;

    // Five errors on ch0: 2-bit counter saturates at 3.
    for (int k = 0; k < 5; k++) begin
      setd(0, 32'h40 + 32'(k), 32'h0);
      step($sformatf("sat%0d", k), 4'b0001, 0, 0, 4'b0001, 1, 4'b0001, 0);
    end
    check("sat.cnt_a", 64'(cnt_a), 64'h0200_0206);
    check("sat.cnt_s", 64'(cnt_s), 64'h8B);
    setd(0, 32'h45, 32'h0); step("clr", 4'b0001, 0, 1, 4'b0001, 1, 4'b0001, 0);
    check("clr.cnt_a", 64'(cnt_a), 64'd0);
    check("clr.cnt_s", 64'(cnt_s), 64'd0);

    // Reset while a request is pending.
    reset = 1'b0;
    step("rst_req", 4'h0, 0, 0, 4'h0, 0, 4'h0, 0);
    check("rst_req.cnt_a", 64'(cnt_a), 64'd0);
    reset = 1'b1;

    // Window A: 4 errors with thresh 4 -> degrade at the wrap edge.
    thresh = 8'd4;
    for (int i = 0; i < 4; i++) setd(i, 32'h0, 32'h0);
    step("winA0", 4'hF, 0, 0, 4'h0, 0, 4'h0, 0);
    for (int i = 0; i < 4; i++) setd(i, 32'h1, 32'h0);
    step("winA1", 4'hF, 0, 0, 4'hF, 1, 4'hF, 0);
    check("winA.cnt_a", 64'(cnt_a), 64'h0101_0101);
    for (int k = 2; k < 8; k++)
      step($sformatf("winA%0d", k), 4'h0, 0, 0, 4'h0, 1, 4'hF, (k == 7));

    // Window B: 3 errors -> degrade drops at the next wrap.
    for (int i = 0; i < 3; i++) setd(i, 32'h2, 32'h0);
    step("winB8", 4'b0111, 0, 0, 4'b0111, 1, 4'hF, 1);
    for (int k = 9; k < 16; k++)
      step($sformatf("winB%0d", k), 4'h0, 0, 0, 4'h0, 1, 4'hF, (k < 15));

    // Window C: thresh 0 disables the flag even with 8 errors.
    thresh = 8'd0;
    for (int i = 0; i < 4; i++) setd(i, 32'h3, 32'h0);
    step("winC16", 4'hF, 0, 0, 4'hF, 1, 4'hF, 0);
    for (int i = 0; i < 4; i++) setd(i, 32'h4, 32'h0);
    step("winC17", 4'hF, 0, 0, 4'hF, 1, 4'hF, 0);
    for (int k = 18; k < 25; k++)
      step($sformatf("winC%0d", k), 4'h0, 0, 0, 4'h0, 1, 4'hF, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
